// File: rtl/next_pc_predictor.sv
// next_pc_predictor
//   Next-PC generation stage feeding the PC register. Holds a direct-mapped
//   branch target buffer (BTB) with a 2-bit saturating direction counter per
//   entry, predicts the successor of the current fetch PC combinationally,
//   resolves EX-stage branch outcomes (redirect + flush on mispredict) and
//   keeps resolved-branch / mispredict statistics.
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous, active-high reset
//   if_pc_i        current fetch PC
//   upd_valid_i    EX resolved a branch/jump this cycle
//   upd_pc_i       PC of the resolved branch
//   upd_taken_i    actual direction
//   upd_target_i   actual taken target
//   upd_pred_npc_i next PC that was predicted for that branch
//   next_pc_o      next fetch PC (to PC register)
//   pred_taken_o   direction prediction for if_pc_i
//   flush_o        mispredict: squash IF/ID and ID/EX
//   branch_cnt_o   resolved branches since reset (wraps)
//   miss_cnt_o     mispredicts since reset (wraps)
module next_pc_predictor #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      if_pc_i,
  input  logic             upd_valid_i,
  input  logic [31:0]      upd_pc_i,
  input  logic             upd_taken_i,
  input  logic [31:0]      upd_target_i,
  input  logic [31:0]      upd_pred_npc_i,
  output logic [31:0]      next_pc_o,
  output logic             pred_taken_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  logic [ENTRIES-1:0] r_valid;
  logic [1:0]         r_ctr    [ENTRIES];
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [CNT_W-1:0]   r_branch_cnt;
  logic [CNT_W-1:0]   r_miss_cnt;

  // Lookup side (fetch PC).
  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;
  logic [31:0]      w_pred_npc;

  assign w_if_idx     = if_pc_i[IDX_W+1:2];
  assign w_if_tag     = if_pc_i[31:IDX_W+2];
  assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign pred_taken_o = w_if_hit && r_ctr[w_if_idx][1];
  assign w_pred_npc   = pred_taken_o ? r_target[w_if_idx] : (if_pc_i + 32'd4);

  // Resolution side (EX-stage branch).
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic [31:0]      w_act_npc;
  logic             w_mispredict;

  assign w_upd_idx    = upd_pc_i[IDX_W+1:2];
  assign w_upd_tag    = upd_pc_i[31:IDX_W+2];
  assign w_upd_hit    = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_act_npc    = upd_taken_i ? upd_target_i : (upd_pc_i + 32'd4);
  assign w_mispredict = upd_valid_i && (w_act_npc != upd_pred_npc_i);

  // A redirect from EX always overrides the fetch-side prediction.
  always_comb begin
    // NOTE: assigning a default before any conditional keeps always_comb
    // free of inferred latches.
    next_pc_o = w_pred_npc;
    if (w_mispredict) next_pc_o = w_act_npc;
  end

  assign flush_o      = w_mispredict;
  assign branch_cnt_o = r_branch_cnt;
  assign miss_cnt_o   = r_miss_cnt;

  // Valid bits and direction counters: the only table state that needs reset.
  // Counters reset to weakly-not-taken; a fresh allocation starts weakly-taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= 2'b01;
    end else if (upd_valid_i) begin
      if (w_upd_hit) begin
        if (upd_taken_i) begin
          if (r_ctr[w_upd_idx] != 2'b11) r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
        end else begin
          if (r_ctr[w_upd_idx] != 2'b00) r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
        end
      end else if (upd_taken_i) begin
        r_valid[w_upd_idx] <= 1'b1;
        r_ctr[w_upd_idx]   <= 2'b10;
      end
    end
  end

  // Tag and target are qualified by the valid bit, so they carry no reset.
  // Every taken update either refreshes a hit (same tag) or allocates, so
  // both fields are written on any taken resolution.
  // NOTE: leaving wide storage without reset lets it map to plain RAM/flops
  // without a reset tree; valid gates every use of it.
  always_ff @(posedge clk_i) begin
    if (upd_valid_i && upd_taken_i) begin
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= upd_target_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (upd_valid_i)  r_branch_cnt <= r_branch_cnt + 1'b1;
      if (w_mispredict) r_miss_cnt   <= r_miss_cnt + 1'b1;
    end
  end

endmodule
